// File: rtl/spi_clgen_mode.sv
// Mode-aware SPI serial-clock generator: latches transfer settings at start, produces
// SCLK for CPOL/CPHA modes 0-3, counts bits and emits sample/shift/done strobes.
module spi_clgen_mode #(
    parameter int DIV_W = 16,
    parameter int LEN_W = 5
) (
    input  logic             wb_clk,
    input  logic             wb_reset_n,
    input  logic             go,
    input  logic             abort,
    input  logic             cpol,
    input  logic             cpha,
    input  logic [DIV_W-1:0] divider,
    input  logic [LEN_W-1:0] char_len,
    output logic             sclk,
    output logic             tip,
    output logic             lstclk,
    output logic             start_stb,
    output logic             sample_stb,
    output logic             shift_stb,
    output logic             done
);

    localparam int EW = LEN_W + 2;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_d;
    logic             cpol_q, cpol_d, cpha_q, cpha_d;
    logic [DIV_W-1:0] div_q, div_d, cnt, cnt_d;
    logic [LEN_W:0]   len_q, len_d;
    logic [EW-1:0]    edge_cnt, edge_d, edge_nxt, last_edge;
    logic             sclk_d, tip_d, start_d, sample_d, shift_d, done_d;
    logic             is_final, is_sample;

    assign edge_nxt  = edge_cnt + EW'(1);
    assign last_edge = {len_q, 1'b0};
    assign is_final  = (edge_nxt == last_edge);
    // Odd edges are leading: sample there in CPHA=0, on trailing edges in CPHA=1.
    assign is_sample = edge_nxt[0] ^ cpha_q;
    assign lstclk    = (state == RUN) && (edge_cnt >= last_edge - EW'(2));

    // NOTE: every signal written below gets its default first so no latch is inferred.
    always_comb begin
        state_d  = state;
        cpol_d   = cpol_q;
        cpha_d   = cpha_q;
        div_d    = div_q;
        len_d    = len_q;
        cnt_d    = cnt;
        edge_d   = edge_cnt;
        sclk_d   = sclk;
        tip_d    = tip;
        start_d  = 1'b0;
        sample_d = 1'b0;
        shift_d  = 1'b0;
        done_d   = 1'b0;
        case (state)
            IDLE: begin
                sclk_d = cpol_q;
                tip_d  = 1'b0;
                if (go) begin
                    state_d = RUN;
                    cpol_d  = cpol;
                    cpha_d  = cpha;
                    div_d   = divider;
                    len_d   = (char_len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, char_len};
                    cnt_d   = divider;
                    edge_d  = '0;
                    sclk_d  = cpol;
                    tip_d   = 1'b1;
                    start_d = 1'b1;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                    tip_d   = 1'b0;
                    sclk_d  = cpol_q;
                end else if (cnt == '0) begin
                    // Down-counter reload keeps div_q+1 from ever being formed at DIV_W width.
                    cnt_d    = div_q;
                    edge_d   = edge_nxt;
                    sample_d = is_sample;
                    shift_d  = !is_sample && !is_final;
                    if (is_final) begin
                        state_d = IDLE;
                        tip_d   = 1'b0;
                        sclk_d  = cpol_q;
                        done_d  = 1'b1;
                    end else begin
                        sclk_d = ~sclk;
                    end
                end else begin
                    cnt_d = cnt - DIV_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge wb_clk or negedge wb_reset_n) begin
        if (!wb_reset_n) begin
            state      <= IDLE;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            div_q      <= '0;
            len_q      <= '0;
            cnt        <= '0;
            edge_cnt   <= '0;
            sclk       <= 1'b0;
            tip        <= 1'b0;
            start_stb  <= 1'b0;
            sample_stb <= 1'b0;
            shift_stb  <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            div_q      <= div_d;
            len_q      <= len_d;
            cnt        <= cnt_d;
            edge_cnt   <= edge_d;
            sclk       <= sclk_d;
            tip        <= tip_d;
            start_stb  <= start_d;
            sample_stb <= sample_d;
            shift_stb  <= shift_d;
            done       <= done_d;
        end
    end

endmodule

// File: tb/tb_spi_clgen_mode.sv
// Directed self-checking bench for spi_clgen_mode: per-transfer edge/strobe statistics
// compared against hand-computed expectations for each mode and boundary case.
module tb_spi_clgen_mode;

    logic        wb_clk;
    logic        wb_reset_n;
    logic        go, abort, cpol, cpha;
    logic [15:0] divider;
    logic [4:0]  char_len;
    logic        sclk, tip, lstclk, start_stb, sample_stb, shift_stb, done;

    int n_checks = 0;
    int n_fail   = 0;

    // Per-transfer statistics filled in by xfer().
    int   tip_cyc, n_lead, n_trail, n_samp, n_shft, samp_lead, shft_lead;
    int   n_lst, first_e, gmin, gmax, n_done, done_bad, bad_stb;
    logic timed_out, end_sclk;

    spi_clgen_mode #(.DIV_W(16), .LEN_W(5)) dut (
        .wb_clk     (wb_clk),
        .wb_reset_n (wb_reset_n),
        .go         (go),
        .abort      (abort),
        .cpol       (cpol),
        .cpha       (cpha),
        .divider    (divider),
        .char_len   (char_len),
        .sclk       (sclk),
        .tip        (tip),
        .lstclk     (lstclk),
        .start_stb  (start_stb),
        .sample_stb (sample_stb),
        .shift_stb  (shift_stb),
        .done       (done)
    );

    initial wb_clk = 1'b0;
    always #5 wb_clk = ~wb_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Starts a transfer from an aligned point (#1 after a rising edge) and runs until tip drops.
    task automatic xfer(input bit p, input bit h, input int div, input int len,
                        input int abort_at, input bit keep_go, input int chg_at, input int chg_div);
        logic prev;
        int   cyc, last_e;
        logic lead;
        cpol     = p;
        cpha     = h;
        divider  = div[15:0];
        char_len = len[4:0];
        go       = 1'b1;
        @(posedge wb_clk); #1;
        check("start.stb",  start_stb, 1);
        check("start.tip",  tip, 1);
        check("start.sclk", sclk, p);
        if (!keep_go) go = 1'b0;
        cpol     = ~p;
        cpha     = ~h;
        char_len = char_len ^ 5'h3;
        tip_cyc = 1; n_lead = 0; n_trail = 0; n_samp = 0; n_shft = 0;
        samp_lead = 0; shft_lead = 0; n_lst = 0; first_e = -1; gmin = 100000; gmax = 0;
        n_done = 0; done_bad = 0; bad_stb = 0;
        prev = sclk; cyc = 0; last_e = 0;
        while (tip && cyc < 5000) begin
            @(posedge wb_clk); #1;
            cyc++;
            if (abort) abort = 1'b0;
            if (sclk != prev) begin
                if (first_e < 0) first_e = cyc;
                else begin
                    if (cyc - last_e < gmin) gmin = cyc - last_e;
                    if (cyc - last_e > gmax) gmax = cyc - last_e;
                end
                last_e = cyc;
                lead = (sclk != p);
                if (lead) n_lead++; else n_trail++;
                if (sample_stb && lead) samp_lead++;
                if (shift_stb && lead) shft_lead++;
            end else if (sample_stb || shift_stb) begin
                bad_stb++;
            end
            if (start_stb) bad_stb++;
            if (sample_stb) n_samp++;
            if (shift_stb) n_shft++;
            if (lstclk) n_lst++;
            if (tip) tip_cyc++;
            if (done) begin
                n_done++;
                if (tip) done_bad++;
            end
            prev = sclk;
            if (cyc == abort_at) abort = 1'b1;
            if (cyc == chg_at) divider = chg_div[15:0];
        end
        timed_out = tip;
        end_sclk  = sclk;
    endtask

    task automatic check_xfer(input string t, input int e_tip, input int e_lead, input int e_trail,
                              input int e_samp, input int e_shft, input int e_sl, input int e_shl,
                              input int e_lst, input int e_first, input int e_gmin, input int e_gmax,
                              input int e_done, input logic e_end);
        check({t, ".timeout"},   timed_out, 0);
        check({t, ".tip_cyc"},   tip_cyc, e_tip);
        check({t, ".lead"},      n_lead, e_lead);
        check({t, ".trail"},     n_trail, e_trail);
        check({t, ".samples"},   n_samp, e_samp);
        check({t, ".shifts"},    n_shft, e_shft);
        check({t, ".samp_lead"}, samp_lead, e_sl);
        check({t, ".shft_lead"}, shft_lead, e_shl);
        check({t, ".lstclk"},    n_lst, e_lst);
        check({t, ".first"},     first_e, e_first);
        check({t, ".gap_min"},   gmin, e_gmin);
        check({t, ".gap_max"},   gmax, e_gmax);
        check({t, ".done"},      n_done, e_done);
        check({t, ".done_tip"},  done_bad, 0);
        check({t, ".stray_stb"}, bad_stb, 0);
        check({t, ".end_sclk"},  end_sclk, e_end);
    endtask

    task automatic check_quiet(input string t);
        check({t, ".sclk"},   sclk, 0);
        check({t, ".tip"},    tip, 0);
        check({t, ".lstclk"}, lstclk, 0);
        check({t, ".start"},  start_stb, 0);
        check({t, ".sample"}, sample_stb, 0);
        check({t, ".shift"},  shift_stb, 0);
        check({t, ".done"},   done, 0);
    endtask

    initial begin
        wb_reset_n = 1'b0;
        go = 1'b0; abort = 1'b0; cpol = 1'b0; cpha = 1'b0;
        divider = '0; char_len = '0;
        #3;
        check_quiet("reset");
        @(posedge wb_clk); #1;
        wb_reset_n = 1'b1;
        @(posedge wb_clk); #1;

        // Mode 0, divider 1, 8 bits
        xfer(0, 0, 1, 8, -1, 0, -1, 0);
        check_xfer("m0", 32, 8, 8, 8, 7, 8, 0, 4, 2, 2, 2, 1, 0);

        // Mode 3, divider 0, 8 bits
        xfer(1, 1, 0, 8, -1, 0, -1, 0);
        check_xfer("m3", 16, 8, 8, 8, 8, 0, 8, 2, 1, 1, 1, 1, 1);

        // char_len 0 encodes 32 bits
        xfer(0, 0, 0, 0, -1, 0, -1, 0);
        check_xfer("len32", 64, 32, 32, 32, 31, 32, 0, 2, 1, 1, 1, 1, 0);

        // Mode 1, divider 3, abort raised right after edge 5 (cycle 20)
        xfer(0, 1, 3, 8, 20, 0, -1, 0);
        check_xfer("abort", 21, 3, 3, 2, 3, 0, 3, 0, 4, 1, 4, 0, 0);
        @(posedge wb_clk); #1;
        check_quiet("post_abort");
        xfer(0, 1, 0, 4, -1, 0, -1, 0);
        check_xfer("after_abort", 8, 4, 4, 4, 4, 0, 4, 2, 1, 1, 1, 1, 0);

        // Asynchronous reset while sclk high and a sample strobe is showing
        cpol = 1'b0; cpha = 1'b0; divider = 16'd1; char_len = 5'd8; go = 1'b1;
        @(posedge wb_clk); #1;
        go = 1'b0;
        repeat (6) @(posedge wb_clk);
        #1;
        check("pre_rst.sclk",   sclk, 1);
        check("pre_rst.sample", sample_stb, 1);
        check("pre_rst.tip",    tip, 1);
        #1 wb_reset_n = 1'b0;
        #1 check_quiet("async_rst");
        #1 wb_reset_n = 1'b1;
        @(posedge wb_clk); #1;
        check("idle_after_rst.sclk", sclk, 0);
        xfer(1, 0, 0, 2, -1, 0, -1, 0);
        check_xfer("m2", 4, 2, 2, 2, 1, 2, 0, 2, 1, 1, 1, 1, 1);

        // go held high; divider changed 2 -> 5 during the first transfer
        xfer(0, 0, 2, 2, -1, 1, 4, 5);
        check_xfer("b2b_1", 12, 2, 2, 2, 1, 2, 0, 6, 3, 3, 3, 1, 0);
        xfer(0, 0, 5, 2, -1, 0, -1, 0);
        check_xfer("b2b_2", 24, 2, 2, 2, 1, 2, 0, 12, 6, 6, 6, 1, 0);

        @(posedge wb_clk); #1;
        check_quiet("final_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
